uart_rx_core: RTL and testbench
===============================

// Module: uart_rx_core
// PURPOSE
//  Parametrised UART receiver; successor to the fixed 8N1 receiver. Configurable bit time, data width,
//  parity and stop bits; 3-sample majority vote at mid-bit; parity/framing/break flags; idle-timeout pulse.
//  Sits between the pad-level rx pin and byte consumers (loopback tx, command parser, FIFO).
// PARAMETERS
//  CLKS_PER_BIT  9   clk cycles per bit (27 MHz / 3 Mbps); must be >= 4
//  DATA_BITS     8   data bits per frame, 5..9, LSB first
//  PARITY        0   0 none, 1 odd, 2 even
//  STOP_BITS     1   stop bits checked, 1..2
//  IDLE_BITS     2   idle bit-times after a frame before idle_timeout pulses
// PORTS
//  clk           in   1          system clock
//  rst_n         in   1          asynchronous reset, active low
//  rx            in   1          serial input, idle high
//  rx_data       out  DATA_BITS  last received word; held until next rx_valid
//  rx_valid      out  1          1-cycle pulse: frame complete, rx_data/flags valid
//  parity_err    out  1          qualifies rx_valid: parity mismatch (0 when PARITY=0)
//  frame_err     out  1          qualifies rx_valid: a stop bit sampled low
//  break_det     out  1          qualifies rx_valid: all data, parity, stop bits low
//  rx_busy       out  1          high from start edge until return to IDLE
//  idle_timeout  out  1          1-cycle pulse, once per idle gap following a frame
// BEHAVIOUR
//  Reset: every output 0; rx edge register = 1 (no false start out of reset); state IDLE.
//  One clock, async-assert/sync-use reset; all outputs registered.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   IDLE:   falling edge (prev=1, rx=0) -> START, bit counter cleared, rx_busy=1 next cycle.
//   Sampling: MID=CLKS_PER_BIT/2; samples at MID-1, MID, MID+1 of each bit; majority (>=2 of 3) = bit.
//   START:  majority 1 -> glitch, back to IDLE, no pulse, no flag. Majority 0 -> DATA at bit end.
//   DATA:   DATA_BITS bits shifted LSB first into a shadow register.
//   PARITY: present only if PARITY!=0; err = (^data ^ pbit) != (PARITY==1).
//   STOP:   STOP_BITS bits; any low -> frame_err. Leave STOP at the MID+1 sample of the last stop
//           bit (half-bit early) so back-to-back frames resync on the next falling edge.
//  Latency: rx_valid rises 1 cycle after the last stop-bit MID+1 sample; rx_data, parity_err,
//   frame_err, break_det update in that same cycle; flags are don't-care when rx_valid=0
//   but held with rx_data.
//  break_det implies frame_err=1; after break, IDLE waits for rx=1 before arming edge detect.
//  Idle timer: cleared on start edge; counts in IDLE while rx=1 after a valid frame; at
//   IDLE_BITS*CLKS_PER_BIT cycles pulses idle_timeout once, then stops until next frame.
//  Counter widths: bit-phase $clog2(CLKS_PER_BIT); bit index $clog2(DATA_BITS+3);
//   idle $clog2(IDLE_BITS*CLKS_PER_BIT+1); no wrap in normal operation.
//  rst_n low mid-frame: frame discarded, no rx_valid, outputs to reset values immediately.
// CONFIGURATION
//  UART_RX_SYNC_EN defined: rx passes a 2-flop synchronizer (reset value 1) before edge detect
//   and sampling; all timing shifts +2 cycles, frame_valid latency otherwise identical.
//  Undefined: rx used directly via the single edge register (board-level pre-synchronised input).
// STRUCTURE
//  Shared include uart_pkg.vh: state encodings (ST_IDLE..ST_STOP), PARITY_NONE/ODD/EVEN,
//   default SYS_CLK_HZ / BAUD constants reused by the tx successor.
//  One sub-module: uart_bit_sampler (phase counter, 3-sample majority, bit_done/bit_val strobes).
// TESTING (CLKS_PER_BIT=9, DATA_BITS=8 unless stated)
//  8N1 send 0x55 -> one rx_valid, rx_data=0x55, all flags 0, rx_busy low after pulse.
//  rx low 2 cycles in IDLE -> no rx_valid, rx_busy high then low within one bit-time.
//  PARITY=2, send 0xA3 with pbit=1 -> rx_valid, parity_err=1; pbit=0 -> parity_err=0.
//  Frame 0x3C with stop bit low -> rx_valid, rx_data=0x3C, frame_err=1, break_det=0.
//  rx low 12 bit-times -> rx_valid, break_det=1, frame_err=1; no new frame until rx high.
//  Back-to-back 0x00,0xFF, 1 stop -> two rx_valid pulses 90 cycles apart; then idle_timeout
//   exactly once 18 cycles after returning to IDLE; single-cycle glitch on a data bit ignored.
//  rst_n asserted mid-DATA -> no rx_valid; outputs 0; next frame 0x81 received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes, default clock/baud,
// and the receive flag payload. Imported by the receiver and the tx successor.
package uart_pkg;

  localparam int unsigned SYS_CLK_HZ  = 27_000_000;
  localparam int unsigned BAUD        = 3_000_000;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Flags that qualify rx_valid, held alongside rx_data.
  typedef struct packed {
    logic parity_err;
    logic frame_err;
    logic break_det;
  } rx_flags_t;

endpackage

// File: rtl/uart_bit_sampler.sv
// Bit-phase counter and 3-sample majority voter for the UART receiver.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   rx_s       : serial input as seen by the receiver
//   run        : receiver is inside a frame (phase advances)
//   clear      : start edge seen, restart phase at 0
//   mid_c      : strobe on the last of the three mid-bit samples
//   end_c      : strobe on the final cycle of the bit
//   bit_c      : majority value, valid with mid_c
module uart_bit_sampler #(
  parameter int unsigned CLKS_PER_BIT = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_s,
  input  logic run,
  input  logic clear,
  output logic mid_c,
  output logic end_c,
  output logic bit_c
);

  localparam int unsigned PH_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned MID  = CLKS_PER_BIT / 2;

  logic [PH_W-1:0] phase_q, phase_d;
  logic [1:0]      ones_q, ones_d;
  logic [1:0]      votes_c;

  // Votes so far including the current sample; max 3 fits in 2 bits.
  assign votes_c = ones_q + {1'b0, rx_s};

  always_comb begin
    phase_d = phase_q;
    ones_d  = ones_q;
    if (clear) begin
      phase_d = '0;
      ones_d  = '0;
    end else if (run) begin
      phase_d = (phase_q == PH_W'(CLKS_PER_BIT - 1)) ? '0 : phase_q + PH_W'(1);
      if (phase_q == PH_W'(MID - 1)) begin
        ones_d = {1'b0, rx_s};
      end else if (phase_q == PH_W'(MID)) begin
        ones_d = votes_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      ones_q  <= '0;
    end else begin
      phase_q <= phase_d;
      ones_q  <= ones_d;
    end
  end

  assign mid_c = run && (phase_q == PH_W'(MID + 1));
  assign end_c = run && (phase_q == PH_W'(CLKS_PER_BIT - 1));
  // At least two of three samples high.
  assign bit_c = votes_c[1];

endmodule

// File: rtl/uart_rx_core.sv
// Parametrised UART receiver: start/data/parity/stop framing with 3-sample
// majority vote, parity/framing/break flags and an idle-gap timeout pulse.
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   rx            : serial input, idle high
//   rx_data       : last received word, held until next rx_valid
//   rx_valid      : 1-cycle pulse, frame complete
//   parity_err    : parity mismatch (qualifies rx_valid)
//   frame_err     : a stop bit sampled low (qualifies rx_valid)
//   break_det     : every data/parity/stop bit low (qualifies rx_valid)
//   rx_busy       : high from start edge until return to IDLE
//   idle_timeout  : 1-cycle pulse once per idle gap after a frame
// Build option: UART_RX_SYNC_EN inserts a 2-flop synchronizer on rx.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = SYS_CLK_HZ / BAUD,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = PARITY_NONE,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned IDLE_BITS    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 rx_busy,
  output logic                 idle_timeout
);

  localparam int unsigned IDX_W      = $clog2(DATA_BITS + 3);
  localparam int unsigned IDLE_LIMIT = IDLE_BITS * CLKS_PER_BIT;
  localparam int unsigned IDLE_W     = $clog2(IDLE_LIMIT + 1);
  localparam logic        PAR_EN     = (PARITY != PARITY_NONE);
  localparam logic        PAR_ODD    = (PARITY == PARITY_ODD);

  logic rx_s;

`ifdef UART_RX_SYNC_EN
  // Two-flop synchronizer, reset high so reset release is not a start edge.
  logic [1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[0], rx};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= sync_d;
  end
  assign rx_s = sync_q[1];
`else
  assign rx_s = rx;
`endif

  uart_state_e          state_q, state_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 ferr_q, ferr_d;
  logic                 high_q, high_d;
  logic                 armed_q, armed_d;
  logic                 rx_prev_q, rx_prev_d;
  logic [IDLE_W-1:0]    idle_cnt_q, idle_cnt_d;
  logic                 idle_en_q, idle_en_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  rx_flags_t            flags_q, flags_d;
  logic                 rx_busy_q, rx_busy_d;
  logic                 idle_timeout_q, idle_timeout_d;

  logic run_c, start_c, mid_c, end_c, bit_c;
  logic stop_ferr_c, stop_high_c, par_err_c;

  assign run_c = (state_q != ST_IDLE);

  uart_bit_sampler #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_sampler (
    .clk   (clk),
    .rst_n (rst_n),
    .rx_s  (rx_s),
    .run   (run_c),
    .clear (start_c),
    .mid_c (mid_c),
    .end_c (end_c),
    .bit_c (bit_c)
  );

  // Error/break accumulation including the stop bit currently being voted.
  assign stop_ferr_c = ferr_q | ~bit_c;
  assign stop_high_c = high_q | bit_c;
  assign par_err_c   = PAR_EN && ((^shift_q ^ par_q) != PAR_ODD);

  // Next-state and output logic.
  always_comb begin
    state_d        = state_q;
    bit_idx_d      = bit_idx_q;
    shift_d        = shift_q;
    par_d          = par_q;
    ferr_d         = ferr_q;
    high_d         = high_q;
    armed_d        = armed_q;
    rx_prev_d      = rx_s;
    idle_cnt_d     = idle_cnt_q;
    idle_en_d      = idle_en_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    flags_d        = flags_q;
    idle_timeout_d = 1'b0;
    start_c        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // After a break the line must go high before a new start is accepted.
        if (rx_s) armed_d = 1'b1;
        if (armed_q && rx_prev_q && !rx_s) begin
          start_c    = 1'b1;
          state_d    = ST_START;
          bit_idx_d  = '0;
          ferr_d     = 1'b0;
          high_d     = 1'b0;
          idle_cnt_d = '0;
        end else if (idle_en_q && rx_s) begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
          if (idle_cnt_d == IDLE_W'(IDLE_LIMIT)) begin
            idle_timeout_d = 1'b1;
            idle_en_d      = 1'b0;
          end
        end
      end

      ST_START: begin
        if (mid_c && bit_c) begin
          state_d = ST_IDLE;
        end else if (end_c) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
        end
      end

      ST_DATA: begin
        if (mid_c) begin
          shift_d = {bit_c, shift_q[DATA_BITS-1:1]};
          high_d  = high_q | bit_c;
        end
        if (end_c) begin
          if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
            state_d   = PAR_EN ? ST_PARITY : ST_STOP;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end

      ST_PARITY: begin
        if (mid_c) begin
          par_d  = bit_c;
          high_d = high_q | bit_c;
        end
        if (end_c) begin
          state_d   = ST_STOP;
          bit_idx_d = '0;
        end
      end

      ST_STOP: begin
        if (mid_c) begin
          if (bit_idx_q == IDX_W'(STOP_BITS - 1)) begin
            // Leave half a bit early so the next start edge is caught.
            state_d            = ST_IDLE;
            rx_valid_d         = 1'b1;
            rx_data_d          = shift_q;
            flags_d.parity_err = par_err_c;
            flags_d.frame_err  = stop_ferr_c;
            flags_d.break_det  = ~stop_high_c;
            idle_en_d          = 1'b1;
            idle_cnt_d         = '0;
            if (!stop_high_c) armed_d = 1'b0;
          end else begin
            ferr_d = stop_ferr_c;
            high_d = stop_high_c;
          end
        end else if (end_c) begin
          bit_idx_d = bit_idx_q + IDX_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    rx_busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      bit_idx_q      <= '0;
      shift_q        <= '0;
      par_q          <= 1'b0;
      ferr_q         <= 1'b0;
      high_q         <= 1'b0;
      armed_q        <= 1'b1;
      rx_prev_q      <= 1'b1;
      idle_cnt_q     <= '0;
      idle_en_q      <= 1'b0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      flags_q        <= '0;
      rx_busy_q      <= 1'b0;
      idle_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_idx_q      <= bit_idx_d;
      shift_q        <= shift_d;
      par_q          <= par_d;
      ferr_q         <= ferr_d;
      high_q         <= high_d;
      armed_q        <= armed_d;
      rx_prev_q      <= rx_prev_d;
      idle_cnt_q     <= idle_cnt_d;
      idle_en_q      <= idle_en_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      flags_q        <= flags_d;
      rx_busy_q      <= rx_busy_d;
      idle_timeout_q <= idle_timeout_d;
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign parity_err   = flags_q.parity_err;
  assign frame_err    = flags_q.frame_err;
  assign break_det    = flags_q.break_det;
  assign rx_busy      = rx_busy_q;
  assign idle_timeout = idle_timeout_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: an 8N1 instance and an 8E1 instance.
module tb_uart_rx_core;

  localparam int CPB = 9;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_p = 1'b1;

  logic [7:0] rx_data, rx_data_p;
  logic       rx_valid, parity_err, frame_err, break_det, rx_busy, idle_timeout;
  logic       rx_valid_p, parity_err_p, frame_err_p, break_det_p, rx_busy_p, idle_timeout_p;

  uart_rx_core dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .parity_err(parity_err),
    .frame_err(frame_err), .break_det(break_det), .rx_busy(rx_busy),
    .idle_timeout(idle_timeout)
  );

  uart_rx_core #(.PARITY(2)) dut_p (
    .clk(clk), .rst_n(rst_n), .rx(rx_p),
    .rx_data(rx_data_p), .rx_valid(rx_valid_p), .parity_err(parity_err_p),
    .frame_err(frame_err_p), .break_det(break_det_p), .rx_busy(rx_busy_p),
    .idle_timeout(idle_timeout_p)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   vc0[$];
  int   n_valid0 = 0, n_valid1 = 0, n_idle0 = 0, n_idle1 = 0, idle_cyc0 = 0;
  exp_t e0, e1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Monitor for the 8N1 instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        n_valid0++;
        vc0.push_back(cyc);
        if (q0.size() == 0) begin
          chk("unexpected_valid0", 32'd1, 32'd0);
        end else begin
          e0 = q0.pop_front();
          chk("data0", 32'(rx_data), 32'(e0.data));
          chk("perr0", 32'(parity_err), 32'(e0.perr));
          chk("ferr0", 32'(frame_err), 32'(e0.ferr));
          chk("brk0",  32'(break_det), 32'(e0.brk));
        end
      end
      if (idle_timeout) begin
        n_idle0++;
        idle_cyc0 = cyc;
      end
    end
  end

  // Monitor for the even-parity instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid_p) begin
        n_valid1++;
        if (q1.size() == 0) begin
          chk("unexpected_valid1", 32'd1, 32'd0);
        end else begin
          e1 = q1.pop_front();
          chk("data1", 32'(rx_data_p), 32'(e1.data));
          chk("perr1", 32'(parity_err_p), 32'(e1.perr));
          chk("ferr1", 32'(frame_err_p), 32'(e1.ferr));
          chk("brk1",  32'(break_det_p), 32'(e1.brk));
        end
      end
      if (idle_timeout_p) n_idle1++;
    end
  end

  task automatic drive(input int sel, input logic v);
    if (sel == 0) rx = v;
    else          rx_p = v;
  endtask

  // One bit-time; optional 1-cycle inversion on the middle sample slot.
  task automatic send_bit(input int sel, input logic v, input bit glitch);
    for (int c = 0; c < CPB; c++) begin
      drive(sel, (glitch && c == 5) ? ~v : v);
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input bit par_en,
                            input logic pbit, input logic stop, input int glitch_idx);
    send_bit(sel, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(sel, d[i], glitch_idx == i);
    if (par_en) send_bit(sel, pbit, 1'b0);
    send_bit(sel, stop, 1'b0);
    drive(sel, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_data",  32'(rx_data), 32'd0);
    chk("rst_busy",  32'(rx_busy), 32'd0);
    chk("rst_flags", {29'd0, parity_err, frame_err, break_det}, 32'd0);
    chk("rst_idle",  32'(idle_timeout), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1 0x55
    q0.push_back('{8'h55, 1'b0, 1'b0, 1'b0});
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1, -1);
    chk("t1_busy_low", 32'(rx_busy), 32'd0);
    chk("t1_count", 32'(n_valid0), 32'd1);
    repeat (3 * CPB) @(negedge clk);

    // Two-cycle start glitch
    drive(0, 1'b0);
    repeat (2) @(negedge clk);
    drive(0, 1'b1);
    chk("t2_busy_high", 32'(rx_busy), 32'd1);
    repeat (CPB) @(negedge clk);
    chk("t2_busy_low", 32'(rx_busy), 32'd0);
    chk("t2_no_valid", 32'(n_valid0), 32'd1);
    repeat (2 * CPB) @(negedge clk);

    // Even parity, 0xA3 (four ones): pbit=1 wrong, pbit=0 right
    q1.push_back('{8'hA3, 1'b1, 1'b0, 1'b0});
    send_frame(1, 8'hA3, 1'b1, 1'b1, 1'b1, -1);
    q1.push_back('{8'hA3, 1'b0, 1'b0, 1'b0});
    send_frame(1, 8'hA3, 1'b1, 1'b0, 1'b1, -1);
    repeat (CPB) @(negedge clk);
    chk("t3_count", 32'(n_valid1), 32'd2);

    // Stop bit low
    q0.push_back('{8'h3C, 1'b0, 1'b1, 1'b0});
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, -1);
    repeat (3 * CPB) @(negedge clk);

    // Break: line low for 12 bit-times
    q0.push_back('{8'h00, 1'b0, 1'b1, 1'b1});
    drive(0, 1'b0);
    repeat (12 * CPB) @(negedge clk);
    chk("t5_busy_low", 32'(rx_busy), 32'd0);
    chk("t5_count", 32'(n_valid0), 32'd3);
    chk("t5_data_held", 32'(rx_data), 32'h00);
    drive(0, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    q0.push_back('{8'h5A, 1'b0, 1'b0, 1'b0});
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1, -1);
    repeat (3 * CPB) @(negedge clk);

    // Back-to-back 0x00, 0xFF (glitch on data bit 3), then idle timeout
    n_idle0 = 0;
    vc0.delete();
    q0.push_back('{8'h00, 1'b0, 1'b0, 1'b0});
    q0.push_back('{8'hFF, 1'b0, 1'b0, 1'b0});
    send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1, -1);
    send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1, 3);
    repeat (4 * CPB) @(negedge clk);
    chk("t6_pulses", 32'(vc0.size()), 32'd2);
    if (vc0.size() == 2) begin
      chk("t6_spacing", 32'(vc0[1] - vc0[0]), 32'd90);
      chk("t6_idle_delay", 32'(idle_cyc0 - vc0[1]), 32'd18);
    end
    chk("t6_idle_count", 32'(n_idle0), 32'd1);

    // Reset in the middle of the data bits
    send_bit(0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(0, 1'b1, 1'b0);
    chk("t7_busy_pre", 32'(rx_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_data",  32'(rx_data), 32'd0);
    chk("t7_rst_busy",  32'(rx_busy), 32'd0);
    chk("t7_rst_valid", 32'(rx_valid), 32'd0);
    chk("t7_rst_flags", {29'd0, parity_err, frame_err, break_det}, 32'd0);
    drive(0, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    q0.push_back('{8'h81, 1'b0, 1'b0, 1'b0});
    send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1, -1);
    repeat (2 * CPB) @(negedge clk);

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("valid_total0", 32'(n_valid0), 32'd7);
    chk("valid_total1", 32'(n_valid1), 32'd2);
    chk("busy_end_p", 32'(rx_busy_p), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
